// File: rtl/addr_gen_sequencer_if.sv
// Handshake and address bus between the NTT stage controller, the bank memories
// and the address generator.
interface addr_gen_sequencer_if #(
  parameter int SIZE = 257,
  parameter int AW   = 8,
  parameter int LW   = 16
);
  logic                 start;
  logic [1:0]           mode;
  logic [LW-1:0]        len;
  logic                 stall;
  logic                 busy;
  logic                 valid;
  logic                 done;
  logic [SIZE*AW-1:0]   addr;

  modport master (output start, mode, len, stall, input busy, valid, done, addr);
  modport slave  (input start, mode, len, stall, output busy, valid, done, addr);
endinterface

// File: rtl/addr_gen_sequencer.sv
// Self-sequencing per-lane bank address generator (linear / rotate / stride steps),
// all lane arithmetic modulo DEPTH.
module addr_gen_lane #(
  parameter int            DEPTH  = 85,
  parameter int            AW     = 8,
  parameter int            STRIDE = 1,
  parameter logic [AW-1:0] INIT   = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          adv,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] rot_src,
  output logic [AW-1:0] q
);
  localparam logic [AW:0] DEP  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STEP = (AW+1)'(STRIDE);

  logic [AW:0]   inc_sum, inc_d, str_sum, str_d;
  logic [AW-1:0] inc_nx, str_nx;

  // One extra bit holds lane+STRIDE < 2*DEPTH, so a single conditional subtract wraps it.
  always_comb begin
    inc_sum = {1'b0, q} + (AW+1)'(1);
    inc_d   = (inc_sum >= DEP) ? inc_sum - DEP : inc_sum;
    inc_nx  = inc_d[AW-1:0];
    str_sum = {1'b0, q} + STEP;
    str_d   = (str_sum >= DEP) ? str_sum - DEP : str_sum;
    str_nx  = str_d[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset)     q <= '0;
    else if (load) q <= (mode == 2'd1) ? INIT : '0;
    else if (adv) begin
      case (mode)
        2'd1:    q <= rot_src;
        2'd2:    q <= str_nx;
        default: q <= inc_nx;
      endcase
    end
  end
endmodule

module addr_gen_sequencer #(
  parameter int SIZE   = 257,
  parameter int DEPTH  = 85,
  parameter int AW     = 8,
  parameter int SHIFT  = 255,
  parameter int STRIDE = 1,
  parameter int LW     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  addr_gen_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                   state, state_nx;
  logic [1:0]               mode_q, lane_mode;
  logic [LW-1:0]            len_q, cnt;
  logic                     load, adv;
  logic [SIZE-1:0][AW-1:0]  lanes;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    adv      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load     = 1'b1;
        state_nx = (bus.len != '0) ? RUN : FIN;
      end
      RUN: if (!bus.stall) begin
        if (cnt == len_q - LW'(1)) state_nx = FIN;
        else                       adv      = 1'b1;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
    end else if (load) begin
      mode_q <= bus.mode;
      len_q  <= bus.len;
      cnt    <= '0;
    end else if (adv) begin
      cnt    <= cnt + LW'(1);
    end
  end

  // The initial pattern follows the mode being accepted; steps follow the latched one.
  assign lane_mode = load ? bus.mode : mode_q;

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    addr_gen_lane #(
      .DEPTH  (DEPTH),
      .AW     (AW),
      .STRIDE (STRIDE),
      .INIT   (AW'(i % DEPTH))
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .adv     (adv),
      .mode    (lane_mode),
      .rot_src (lanes[(i + SHIFT) % SIZE]),
      .q       (lanes[i])
    );
  end

  assign bus.busy  = (state != IDLE);
  assign bus.valid = (state == RUN);
  assign bus.done  = (state == FIN);
  assign bus.addr  = lanes;
endmodule
